// File: rtl/mem_axi_slave.sv
// mem_axi_slave: AXI4 INCR-burst slave over a MEM_DEPTH x AXI_DATA_WIDTH array,
// with independent write (AW/W/B) and read (AR/R) state machines.
module mem_axi_slave #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 512,
  parameter int MEM_DEPTH = 1024
) (
  input  logic                        s_axi_aclk,
  input  logic                        s_axi_aresetn,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [15:0]                 s_axi_awid,
  input  logic [7:0]                  s_axi_awlen,
  input  logic                        s_axi_awvalid,
  output logic                        s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                        s_axi_wlast,
  input  logic                        s_axi_wvalid,
  output logic                        s_axi_wready,
  output logic [15:0]                 s_axi_bid,
  output logic [1:0]                  s_axi_bresp,
  output logic                        s_axi_bvalid,
  input  logic                        s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [15:0]                 s_axi_arid,
  input  logic [7:0]                  s_axi_arlen,
  input  logic                        s_axi_arvalid,
  output logic                        s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [15:0]                 s_axi_rid,
  output logic [1:0]                  s_axi_rresp,
  output logic                        s_axi_rlast,
  output logic                        s_axi_rvalid,
  input  logic                        s_axi_rready
);
  localparam int ADDR_LSB = $clog2(AXI_DATA_WIDTH/8);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int STRB_W = AXI_DATA_WIDTH/8;
  localparam int EXT_W = AXI_ADDR_WIDTH + 9;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic live;
  logic [IDX_W-1:0] w_idx, r_idx;
  logic [7:0] w_cnt, w_len, r_cnt, r_len;
  logic [15:0] w_id, r_id;
  logic w_err, r_err;
  logic [AXI_DATA_WIDTH-1:0] r_word;
  logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic aw_hs, w_hs, w_end, ar_hs, r_hs;
  // Widened so the word index plus burst length cannot wrap before the compare.
  function automatic logic out_of_range(input logic [AXI_ADDR_WIDTH-1:0] a, input logic [7:0] len);
    logic [EXT_W-1:0] last;
    last = EXT_W'(a >> ADDR_LSB) + EXT_W'(len);
    return last >= EXT_W'(MEM_DEPTH);
  endfunction
  // live keeps the address channels closed until the first edge after reset release.
  assign s_axi_awready = live && w_state == W_IDLE;
  assign s_axi_wready = w_state == W_DATA;
  assign s_axi_bvalid = w_state == W_RESP;
  assign s_axi_bid = w_id;
  assign s_axi_bresp = {s_axi_bvalid && w_err, 1'b0};
  assign s_axi_arready = live && r_state == R_IDLE;
  assign s_axi_rvalid = r_state == R_DATA;
  assign s_axi_rid = r_id;
  assign s_axi_rresp = {s_axi_rvalid && r_err, 1'b0};
  assign s_axi_rlast = s_axi_rvalid && r_cnt == r_len;
  assign s_axi_rdata = s_axi_rvalid && !r_err ? r_word : '0;
  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs = s_axi_wvalid && s_axi_wready;
  assign w_end = w_cnt == w_len;
  assign ar_hs = s_axi_arvalid && s_axi_arready;
  assign r_hs = s_axi_rvalid && s_axi_rready;
  always_comb begin
    w_next = w_state;
    if (w_state == W_IDLE && aw_hs) w_next = W_DATA;
    if (w_state == W_DATA && w_hs && (w_end || s_axi_wlast)) w_next = W_RESP;
    if (w_state == W_RESP && s_axi_bready) w_next = W_IDLE;
  end
  always_comb begin
    r_next = r_state;
    if (r_state == R_IDLE && ar_hs) r_next = R_FETCH;
    if (r_state == R_FETCH) r_next = R_DATA;
    if (r_hs) r_next = s_axi_rlast ? R_IDLE : R_FETCH;
  end
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      live <= 1'b0;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
      live <= 1'b1;
    end
  end
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      w_idx <= '0;
      w_cnt <= '0;
      w_len <= '0;
      w_id <= '0;
      w_err <= 1'b0;
      r_idx <= '0;
      r_cnt <= '0;
      r_len <= '0;
      r_id <= '0;
      r_err <= 1'b0;
    end else begin
      if (aw_hs) begin
        w_idx <= s_axi_awaddr[ADDR_LSB +: IDX_W];
        w_cnt <= '0;
        w_len <= s_axi_awlen;
        w_id <= s_axi_awid;
        w_err <= out_of_range(s_axi_awaddr, s_axi_awlen);
      end
      if (w_hs) begin
        w_idx <= w_idx + 1'b1;
        w_cnt <= w_cnt + 1'b1;
        if (s_axi_wlast != w_end) w_err <= 1'b1;
      end
      if (ar_hs) begin
        r_idx <= s_axi_araddr[ADDR_LSB +: IDX_W];
        r_cnt <= '0;
        r_len <= s_axi_arlen;
        r_id <= s_axi_arid;
        r_err <= out_of_range(s_axi_araddr, s_axi_arlen);
      end
      if (r_hs && !s_axi_rlast) begin
        r_idx <= r_idx + 1'b1;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
  // Array is never reset; nonblocking read and write in one block give read-first collisions.
  always_ff @(posedge s_axi_aclk) begin
    if (w_hs && !w_err)
      for (int i = 0; i < STRB_W; i++)
        if (s_axi_wstrb[i]) mem[w_idx][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
    if (r_state == R_FETCH) r_word <= mem[r_idx];
  end
endmodule

// File: tb/tb_mem_axi_slave.sv
// tb_mem_axi_slave: directed bench for mem_axi_slave; drives and samples on the falling edge.
module tb_mem_axi_slave;
  logic clk = 1'b0;
  logic s_axi_aresetn;
  logic [31:0] s_axi_awaddr, s_axi_araddr;
  logic [15:0] s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
  logic [7:0] s_axi_awlen, s_axi_arlen;
  logic s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic [511:0] s_axi_wdata, s_axi_rdata;
  logic [63:0] s_axi_wstrb;
  logic [1:0] s_axi_bresp, s_axi_rresp;
  logic s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic s_axi_rlast, s_axi_rvalid, s_axi_rready;
  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [511:0] rd_q[$];
  logic [1:0] rr_q[$];
  logic rl_q[$];
  int rc_q[$];

  mem_axi_slave dut (
    .s_axi_aclk(clk), .s_axi_aresetn(s_axi_aresetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awid(s_axi_awid), .s_axi_awlen(s_axi_awlen),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arid(s_axi_arid), .s_axi_arlen(s_axi_arlen),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rid(s_axi_rid), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [511:0] pat(input logic [31:0] v);
    return {16{v}};
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [15:0] id, input logic [7:0] len,
                          input int nb, input int lb, input logic [63:0] st, input logic [31:0] b,
                          output logic [1:0] resp, output logic [15:0] bidv);
    int n;
    n = 0;
    s_axi_awaddr = a; s_axi_awid = id; s_axi_awlen = len; s_axi_awvalid = 1'b1;
    while (!s_axi_awready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    for (int i = 0; i < nb; i++) begin
      s_axi_wdata = pat(b + 32'(i)); s_axi_wstrb = st; s_axi_wlast = (i == lb); s_axi_wvalid = 1'b1;
      while (!s_axi_wready && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    while (!s_axi_bvalid && n < 100) begin @(negedge clk); n++; end
    resp = s_axi_bresp; bidv = s_axi_bid;
    s_axi_bready = 1'b1;
    @(negedge clk);
    s_axi_bready = 1'b0;
    chk("write_timeout", 512'(n < 100), 512'd1);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [15:0] id, input logic [7:0] len,
                         input bit rnd, input int abort);
    int n, got;
    bit stop, held, aborted;
    logic [511:0] hold_d;
    n = 0; got = 0; stop = 0; held = 0; aborted = 0; hold_d = '0;
    rd_q.delete(); rr_q.delete(); rl_q.delete(); rc_q.delete();
    s_axi_araddr = a; s_axi_arid = id; s_axi_arlen = len; s_axi_arvalid = 1'b1;
    while (!s_axi_arready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    while (!stop && n < 300) begin
      s_axi_rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (s_axi_rvalid) begin
        if (held) chk("r_hold", s_axi_rdata, hold_d);
        if (got == abort) begin
          s_axi_aresetn = 1'b0; s_axi_rready = 1'b0; stop = 1; aborted = 1;
        end else if (s_axi_rready) begin
          rd_q.push_back(s_axi_rdata); rr_q.push_back(s_axi_rresp);
          rl_q.push_back(s_axi_rlast); rc_q.push_back(cyc);
          chk("rid", 512'(s_axi_rid), 512'(id));
          held = 0; got++;
          if (s_axi_rlast) stop = 1;
        end else begin
          held = 1; hold_d = s_axi_rdata;
        end
      end
      if (!stop) begin @(negedge clk); n++; end
    end
    chk("read_timeout", 512'(stop), 512'd1);
    if (!aborted) begin @(negedge clk); s_axi_rready = 1'b0; end
  endtask

  initial begin
    logic [1:0] resp;
    logic [15:0] bidv;
    s_axi_aresetn = 1'b0;
    s_axi_awaddr = '0; s_axi_awid = '0; s_axi_awlen = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arid = '0; s_axi_arlen = '0;
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_awready", 512'(s_axi_awready), 512'd0);
    chk("rst_arready", 512'(s_axi_arready), 512'd0);
    chk("rst_wready", 512'(s_axi_wready), 512'd0);
    chk("rst_bvalid", 512'(s_axi_bvalid), 512'd0);
    chk("rst_rvalid", 512'(s_axi_rvalid), 512'd0);
    chk("rst_rlast", 512'(s_axi_rlast), 512'd0);
    chk("rst_rdata", s_axi_rdata, 512'd0);
    chk("rst_ids", 512'({s_axi_bid, s_axi_rid}), 512'd0);
    chk("rst_resps", 512'({s_axi_bresp, s_axi_rresp}), 512'd0);
    s_axi_aresetn = 1'b1;
    @(negedge clk);
    chk("awready_up", 512'(s_axi_awready), 512'd1);
    chk("arready_up", 512'(s_axi_arready), 512'd1);

    do_write(32'h40, 16'h1234, 8'd3, 4, 3, '1, 32'h1000_0000, resp, bidv);
    chk("wr1_bresp", 512'(resp), 512'd0);
    chk("wr1_bid", 512'(bidv), 512'h1234);
    do_read(32'h40, 16'h0055, 8'd3, 1'b0, -1);
    chk("rd1_beats", 512'(rd_q.size()), 512'd4);
    for (int i = 0; i < 4 && i < rd_q.size(); i++) begin
      chk("rd1_data", rd_q[i], pat(32'h1000_0000 + 32'(i)));
      chk("rd1_resp", 512'(rr_q[i]), 512'd0);
      chk("rd1_last", 512'(rl_q[i]), 512'(i == 3));
      if (i > 0) chk("rd1_gap", 512'(rc_q[i] - rc_q[i-1]), 512'd2);
    end

    do_write(32'h140, 16'h0005, 8'd0, 1, 0, '1, 32'h2000_0000, resp, bidv);
    chk("wr5_bresp", 512'(resp), 512'd0);
    do_write(32'h140, 16'h0006, 8'd0, 1, 0, 64'hF, 32'hFFFF_FFFF, resp, bidv);
    chk("strb_bresp", 512'(resp), 512'd0);
    do_read(32'h140, 16'h0007, 8'd0, 1'b0, -1);
    chk("strb_beats", 512'(rd_q.size()), 512'd1);
    if (rd_q.size() > 0) chk("strb_data", rd_q[0], {{15{32'h2000_0000}}, 32'hFFFF_FFFF});

    do_write(32'hFFC0, 16'h0008, 8'd0, 1, 0, '1, 32'h4000_0000, resp, bidv);
    chk("top_bresp", 512'(resp), 512'd0);
    do_read(32'hFFC0, 16'h0009, 8'd1, 1'b0, -1);
    chk("oor_rd_beats", 512'(rd_q.size()), 512'd2);
    for (int i = 0; i < 2 && i < rd_q.size(); i++) begin
      chk("oor_rd_data", rd_q[i], 512'd0);
      chk("oor_rd_resp", 512'(rr_q[i]), 512'd2);
      chk("oor_rd_last", 512'(rl_q[i]), 512'(i == 1));
    end
    do_write(32'hFFC0, 16'h000A, 8'd1, 2, 1, '1, 32'h3000_0000, resp, bidv);
    chk("oor_wr_bresp", 512'(resp), 512'd2);
    chk("oor_wr_bid", 512'(bidv), 512'h000A);
    do_read(32'hFFC0, 16'h000B, 8'd0, 1'b0, -1);
    chk("oor_unchanged", rd_q.size() > 0 ? rd_q[0] : 512'd0, pat(32'h4000_0000));
    chk("top_rd_resp", rr_q.size() > 0 ? 512'(rr_q[0]) : 512'd3, 512'd0);

    do_write(32'h200, 16'h0BAD, 8'd3, 2, 1, '1, 32'h5000_0000, resp, bidv);
    chk("early_last_bresp", 512'(resp), 512'd2);
    do_write(32'h280, 16'h000C, 8'd3, 4, 3, '1, 32'h6000_0000, resp, bidv);
    chk("next_aw_bresp", 512'(resp), 512'd0);
    chk("next_aw_bid", 512'(bidv), 512'h000C);
    do_read(32'h200, 16'h000D, 8'd5, 1'b1, -1);
    chk("rnd_beats", 512'(rd_q.size()), 512'd6);
    for (int i = 0; i < 6 && i < rd_q.size(); i++) begin
      chk("rnd_data", rd_q[i], i < 2 ? pat(32'h5000_0000 + 32'(i)) : pat(32'h6000_0000 + 32'(i - 2)));
      chk("rnd_resp", 512'(rr_q[i]), 512'd0);
      chk("rnd_last", 512'(rl_q[i]), 512'(i == 5));
    end

    do_read(32'h40, 16'h000E, 8'd3, 1'b0, 1);
    #1;
    chk("abort_rvalid_now", 512'(s_axi_rvalid), 512'd0);
    @(negedge clk);
    chk("abort_rvalid", 512'(s_axi_rvalid), 512'd0);
    chk("abort_rdata", s_axi_rdata, 512'd0);
    chk("abort_arready", 512'(s_axi_arready), 512'd0);
    s_axi_aresetn = 1'b1;
    @(negedge clk);
    chk("abort_arready_up", 512'(s_axi_arready), 512'd1);
    do_read(32'h40, 16'h000F, 8'd3, 1'b0, -1);
    chk("post_rst_beats", 512'(rd_q.size()), 512'd4);
    for (int i = 0; i < 4 && i < rd_q.size(); i++)
      chk("post_rst_data", rd_q[i], pat(32'h1000_0000 + 32'(i)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_axi_slave.md
MEM_AXI_SLAVE -- requirements
Module: mem_axi_slave

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- AXI_ADDR_WIDTH, 32, byte-address width.
- AXI_DATA_WIDTH, 512, data width; ADDR_LSB = log2(AXI_DATA_WIDTH/8).
- MEM_DEPTH, 1024, number of AXI_DATA_WIDTH words; power of two.

REQ-002 Ports (name, direction, width, meaning):
- s_axi_aclk  in  1  clock; the block has one clock.
- s_axi_aresetn  in  1  reset; asynchronous, active-low.
- s_axi_awaddr  in  AXI_ADDR_WIDTH  write start byte address.
- s_axi_awid  in  16  write ID.
- s_axi_awlen  in  8  write beats minus 1.
- s_axi_awvalid  in  1  AW valid.
- s_axi_awready  out  1  AW ready.
- s_axi_wdata  in  AXI_DATA_WIDTH  write data.
- s_axi_wstrb  in  AXI_DATA_WIDTH/8  byte enables.
- s_axi_wlast  in  1  last write beat.
- s_axi_wvalid  in  1  W valid.
- s_axi_wready  out  1  W ready.
- s_axi_bid  out  16  echoed awid.
- s_axi_bresp  out  2  write response.
- s_axi_bvalid  out  1  B valid.
- s_axi_bready  in  1  B ready.
- s_axi_araddr  in  AXI_ADDR_WIDTH  read start byte address.
- s_axi_arid  in  16  read ID.
- s_axi_arlen  in  8  read beats minus 1.
- s_axi_arvalid  in  1  AR valid.
- s_axi_arready  out  1  AR ready.
- s_axi_rdata  out  AXI_DATA_WIDTH  read data.
- s_axi_rid  out  16  echoed arid.
- s_axi_rresp  out  2  read response.
- s_axi_rlast  out  1  last read beat.
- s_axi_rvalid  out  1  R valid.
- s_axi_rready  in  1  R ready.

Function
REQ-003 Storage: MEM_DEPTH x AXI_DATA_WIDTH array with independent write and read ports.
- Word index = addr[ADDR_LSB +: log2(MEM_DEPTH)].
- Every burst is INCR; word index advances by 1 per beat.
- Burst size is always full data width.

REQ-004 Range check at address acceptance:
- Condition: (addr >> ADDR_LSB) + len >= MEM_DEPTH, computed with no truncation.
- If true, the burst is flagged as an error.

REQ-005 Write FSM has three states: W_IDLE, W_DATA, W_RESP.
- W_IDLE: awready=1. On awvalid, capture addr/id/len, clear the beat counter and go to W_DATA.

REQ-006 W_DATA: wready=1.
- Each wvalid&wready beat writes the bytes enabled by wstrb, unless the burst is error-flagged.
- Each beat increments the beat counter and the word index.

REQ-007 W_DATA exit:
- On the beat where counter==len, or on an earlier beat with wlast=1, go to W_RESP.
- A mismatch between wlast and counter==len sets the error flag.
- Beats already written are not rolled back.

REQ-008 W_RESP: bvalid=1, bid=captured id, bresp=2'b10 if error-flagged else 2'b00.
- bvalid holds until bready, then the FSM returns to W_IDLE.
- awready and wready are 0 in this state.

REQ-009 Read FSM has three states: R_IDLE, R_FETCH, R_DATA.
- R_IDLE: arready=1. On arvalid, capture addr/id/len and go to R_FETCH.

REQ-010 R_FETCH: one-cycle synchronous array read, then go to R_DATA.

REQ-011 R_DATA: rvalid=1, rid=captured id.
- rdata = array word, or 0 if error-flagged.
- rresp = 2'b10 if error-flagged else 2'b00.
- rlast=1 when counter==len.
- rdata, rresp and rlast are stable while rvalid=1 and rready=0.

REQ-012 R_DATA exit on rready:
- If rlast=1, go to R_IDLE.
- Otherwise advance the index and counter and go to R_FETCH.
- Throughput: one beat per 2 cycles.

REQ-013 Concurrency and collisions:
- Read and write FSMs run concurrently; each has at most one outstanding burst.
- Same-cycle read and write to the same word returns the old data (read-first).

REQ-014 Handshake rules:
- Any valid, once asserted, never drops before its handshake completes.
- awready and arready are combinational decodes of the state register only, never of input valids.

Reset
REQ-015 While s_axi_aresetn=0:
- Both FSMs are in IDLE.
- bvalid, rvalid, rlast, wready = 0; bresp, rresp, bid, rid, rdata = 0.
- awready and arready = 0 while in reset; they are 1 from the first clock edge after deassertion.

REQ-016 Reset mid-burst aborts immediately:
- No B or R response is issued for the aborted burst.
- Array contents are not cleared; beats written before reset persist.

Verification
REQ-017 Write awaddr=0x40, awlen=3, 4 beats of data A..D with wlast on beat 4 -> bresp=00, bid echoed; words 1..4 = A..D.
REQ-018 Read araddr=0x40, arlen=3, rready held 1 -> rdata A..D, rresp=00, rlast only on beat 4, rvalid every other cycle.
REQ-019 Write with wstrb=0x...0F to word 5 -> only the low 4 bytes change; read back confirms.
REQ-020 araddr=(MEM_DEPTH-1)<<ADDR_LSB, arlen=1 -> both beats rresp=10, rdata=0; write with the same address -> bresp=10, array unchanged.
REQ-021 awlen=3 with wlast on beat 2 -> bresp=10; next AW accepted normally. rready toggled randomly -> no beat lost or duplicated.
REQ-022 Assert reset during read beat 2 of 4 -> rvalid=0 on the next cycle; after release, a fresh read returns correct data.
